// File: rtl/spi_slave_rx_4ch.sv
// SPI responder for the 4-channel measurement link.
// Deserialises 16-bit MSB-first MOSI frames into CH0..CH3 in frame order,
// strobes per word and per 4-word burst, and returns a status word on MISO.
module spi_slave_rx_4ch #(
   parameter int unsigned GAP_TIMEOUT  = 64,
   parameter logic [15:0] RESP_DEFAULT = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sck,
   input  logic        ss,
   input  logic        mosi,
   output logic        miso,
   input  logic [15:0] tx_data,
   output logic [15:0] ch0_data,
   output logic [15:0] ch1_data,
   output logic [15:0] ch2_data,
   output logic [15:0] ch3_data,
   output logic        word_valid,
   output logic [1:0]  word_ch,
   output logic        burst_valid,
   output logic        frame_err
);

   localparam int unsigned GW = $clog2(GAP_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // synchroniser and history stages
   logic sck_s1_q, sck_s2_q, sck_h_q;
   logic ss_s1_q, ss_s2_q, ss_h_q;
   logic mosi_s1_q, mosi_s2_q, mosi_h_q;

   logic sck_fall, ss_fall, ss_rise;

   state_t        state_q, state_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   shift_q, shift_d;
   logic [15:0]   resp_q, resp_d;
   logic          miso_q, miso_d;
   logic [15:0]   ch_q [4];
   logic [15:0]   ch_d [4];
   logic          wv_q, wv_d;
   logic [1:0]    wch_q, wch_d;
   logic          bv_q, bv_d;
   logic          fe_q, fe_d;
   logic [15:0]   word;

   // 2-FF synchronisers plus history FF; SS rests high so no edge fires out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_s1_q  <= 1'b0;
         sck_s2_q  <= 1'b0;
         sck_h_q   <= 1'b0;
         ss_s1_q   <= 1'b1;
         ss_s2_q   <= 1'b1;
         ss_h_q    <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         mosi_h_q  <= 1'b0;
      end else begin
         sck_s1_q  <= sck;
         sck_s2_q  <= sck_s1_q;
         sck_h_q   <= sck_s2_q;
         ss_s1_q   <= ss;
         ss_s2_q   <= ss_s1_q;
         ss_h_q    <= ss_s2_q;
         mosi_s1_q <= mosi;
         mosi_s2_q <= mosi_s1_q;
         mosi_h_q  <= mosi_s2_q;
      end
   end

   // edge detects on synchronised stage 2 versus history
   always_comb begin
      sck_fall = sck_h_q & ~sck_s2_q;
      ss_fall  = ss_h_q & ~ss_s2_q;
      ss_rise  = ~ss_h_q & ss_s2_q;
      // mosi_h_q is the MOSI sample aligned with the last SCK-high sample,
      // so it is the bit held steady across the falling edge
      word     = {shift_q[14:0], mosi_h_q};
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         resp_q    <= RESP_DEFAULT;
         miso_q    <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) ch_q[i] <= '0;
         wv_q      <= 1'b0;
         wch_q     <= '0;
         bv_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         resp_q    <= resp_d;
         miso_q    <= miso_d;
         for (int unsigned i = 0; i < 4; i++) ch_q[i] <= ch_d[i];
         wv_q      <= wv_d;
         wch_q     <= wch_d;
         bv_q      <= bv_d;
         fe_q      <= fe_d;
      end
   end

   // next-state, shifting, word commit and strobes
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_d     = gap_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      resp_d    = resp_q;
      miso_d    = miso_q;
      for (int unsigned i = 0; i < 4; i++) ch_d[i] = ch_q[i];
      wv_d      = 1'b0;
      wch_d     = wch_q;
      bv_d      = 1'b0;
      fe_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_SHIFT;
               resp_d    = tx_data;
               miso_d    = tx_data[15];
               bit_cnt_d = '0;
               gap_d     = '0;
            end else if (ss_s2_q) begin
               if (gap_q != GW'(GAP_TIMEOUT)) gap_d = gap_q + GW'(1);
               if (gap_d == GW'(GAP_TIMEOUT)) idx_d = '0;
            end
         end

         ST_SHIFT: begin
            // SS edges win over SCK, except a 16th fall coincident with SS rise
            if (ss_rise) begin
               state_d = ST_IDLE;
               miso_d  = 1'b0;
               if (sck_fall && bit_cnt_q == 5'd15) begin
                  ch_d[idx_q] = word;
                  wv_d        = 1'b1;
                  wch_d       = idx_q;
                  bv_d        = (idx_q == 2'd3);
                  idx_d       = idx_q + 2'd1;
                  bit_cnt_d   = 5'd16;
               end else if (bit_cnt_q != 5'd0) begin
                  fe_d  = 1'b1;
                  idx_d = '0;
               end
            end else if (sck_fall) begin
               shift_d   = word;
               bit_cnt_d = bit_cnt_q + 5'd1;
               resp_d    = {resp_q[14:0], 1'b0};
               miso_d    = resp_q[14];
               if (bit_cnt_q == 5'd15) begin
                  ch_d[idx_q] = word;
                  wv_d        = 1'b1;
                  wch_d       = idx_q;
                  bv_d        = (idx_q == 2'd3);
                  idx_d       = idx_q + 2'd1;
                  state_d     = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            if (ss_rise) begin
               state_d = ST_IDLE;
               miso_d  = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // output mapping
   always_comb begin
      miso        = miso_q;
      ch0_data    = ch_q[0];
      ch1_data    = ch_q[1];
      ch2_data    = ch_q[2];
      ch3_data    = ch_q[3];
      word_valid  = wv_q;
      word_ch     = wch_q;
      burst_valid = bv_q;
      frame_err   = fe_q;
   end

endmodule

// File: tb/tb_spi_slave_rx_4ch.sv
// Directed self-checking bench for spi_slave_rx_4ch.
module tb_spi_slave_rx_4ch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck = 1'b0;
   logic        ss = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic [15:0] tx_data = 16'h0000;
   logic [15:0] ch0_data, ch1_data, ch2_data, ch3_data;
   logic        word_valid;
   logic [1:0]  word_ch;
   logic        burst_valid;
   logic        frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   int wv_cnt = 0, bv_cnt = 0, fe_cnt = 0, bv_bad = 0;
   logic [7:0] ch_seq = '0;
   logic [1:0] last_ch = '0;
   logic [15:0] rx;
   int wv0, fe0;

   spi_slave_rx_4ch #(.GAP_TIMEOUT(64), .RESP_DEFAULT(16'h0000)) dut (
      .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
      .tx_data(tx_data),
      .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
      .word_valid(word_valid), .word_ch(word_ch),
      .burst_valid(burst_valid), .frame_err(frame_err)
   );

   always #6 clk = ~clk;

   // strobe monitor, sampled on the opposite edge
   always @(negedge clk) begin
      if (word_valid) begin
         wv_cnt++;
         ch_seq  <= {ch_seq[5:0], word_ch};
         last_ch <= word_ch;
      end
      if (burst_valid) begin
         bv_cnt++;
         if (!(word_valid && word_ch == 2'd3)) bv_bad++;
      end
      if (frame_err) fe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one master frame: SCK period 4 clk, MOSI changes with SCK rise,
   // MISO captured 1 clk after each SCK fall
   task automatic frame(input logic [15:0] d, input int nbits, input bit do_rst,
                        input int gap, output logic [15:0] r);
      r  = '0;
      ss = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 16) ? d[15-i] : 1'b1;
         sck  = 1'b1;
         repeat (2) @(negedge clk);
         sck = 1'b0;
         @(negedge clk);
         r = {r[14:0], miso};
         @(negedge clk);
      end
      if (do_rst) begin
         rst = 1'b1;
         ss  = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end else begin
         repeat (4) @(negedge clk);
         ss = 1'b1;
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ch", {ch0_data | ch1_data | ch2_data | ch3_data}, 32'h0);
      check("reset_strobes", {word_valid, burst_valid, frame_err, word_ch}, 32'h0);
      check("reset_miso", miso, 32'h0);

      // one burst, with MISO response checks on frames 1 and 2
      tx_data = 16'hA5C3;
      frame(16'h1234, 16, 1'b0, 8, rx);
      check("miso_a5c3", rx, 32'hA5C3);
      tx_data = 16'h0F0F;
      frame(16'hABCD, 16, 1'b0, 8, rx);
      check("miso_0f0f", rx, 32'h0F0F);
      frame(16'h0000, 16, 1'b0, 8, rx);
      frame(16'hFFFF, 16, 1'b0, 8, rx);
      check("burst_ch0", ch0_data, 32'h1234);
      check("burst_ch1", ch1_data, 32'hABCD);
      check("burst_ch2", ch2_data, 32'h0000);
      check("burst_ch3", ch3_data, 32'hFFFF);
      check("burst_wv_cnt", wv_cnt, 32'd4);
      check("burst_ch_seq", ch_seq, 32'b00_01_10_11);
      check("burst_bv_cnt", bv_cnt, 32'd1);
      check("burst_bv_align", bv_bad, 32'd0);

      // aborted second frame
      frame(16'h1111, 16, 1'b0, 8, rx);
      frame(16'h5A5A, 7, 1'b0, 8, rx);
      check("abort_fe_cnt", fe_cnt, 32'd1);
      check("abort_ch1_kept", ch1_data, 32'hABCD);
      frame(16'h2222, 16, 1'b0, 8, rx);
      check("abort_resync_ch0", ch0_data, 32'h2222);
      check("abort_resync_ch", last_ch, 32'd0);

      // long gap resynchronises to CH0
      frame(16'h3333, 16, 1'b0, 8, rx);
      frame(16'h4444, 16, 1'b0, 70, rx);
      frame(16'h0042, 16, 1'b0, 8, rx);
      check("gap70_ch0", ch0_data, 32'h0042);
      check("gap70_ch", last_ch, 32'd0);
      check("gap70_ch2", ch2_data, 32'h4444);

      // short gap keeps counting
      frame(16'h5555, 16, 1'b0, 8, rx);
      frame(16'h6666, 16, 1'b0, 40, rx);
      frame(16'h0043, 16, 1'b0, 8, rx);
      check("gap40_ch3", ch3_data, 32'h0043);
      check("gap40_ch", last_ch, 32'd3);
      check("gap40_ch0_kept", ch0_data, 32'h0042);

      // reset at bit 9
      fe0 = fe_cnt;
      frame(16'h9999, 9, 1'b1, 0, rx);
      check("rst_ch", {ch0_data | ch1_data | ch2_data | ch3_data}, 32'h0);
      check("rst_strobes", {word_valid, burst_valid, frame_err, word_ch, miso}, 32'h0);
      repeat (8) @(negedge clk);
      check("rst_no_fe", fe_cnt - fe0, 32'd0);
      frame(16'hC001, 16, 1'b0, 8, rx);
      frame(16'hC002, 16, 1'b0, 8, rx);
      frame(16'hC003, 16, 1'b0, 8, rx);
      frame(16'hC004, 16, 1'b0, 8, rx);
      check("post_rst_ch0", ch0_data, 32'hC001);
      check("post_rst_ch1", ch1_data, 32'hC002);
      check("post_rst_ch2", ch2_data, 32'hC003);
      check("post_rst_ch3", ch3_data, 32'hC004);

      // 20 SCK pulses in one SS window
      wv0 = wv_cnt;
      frame(16'h8001, 20, 1'b0, 8, rx);
      check("extra_ch0", ch0_data, 32'h8001);
      check("extra_wv_one", wv_cnt - wv0, 32'd1);
      check("extra_ch1_kept", ch1_data, 32'hC002);
      check("final_bv_align", bv_bad, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
